challengeqsys_mul_sequencer: RTL and testbench

CHALLENGEQSYS_MUL_SEQUENCER -- requirements
Module: challengeqsys_mul_sequencer

---
 rtl/challengeqsys_mul_pkg.sv | 41 ++++
 rtl/challengeqsys_mul_pp16.sv | 28 ++
 rtl/challengeqsys_mul_sequencer.sv | 156 +++++++++++++++
 tb/tb_challengeqsys_mul_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/challengeqsys_mul_pkg.sv
// Shared definitions for the sequenced 32x32 multiplier: operation encodings,
// controller states, datapath widths and partial-product alignment.
package challengeqsys_mul_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned ACC_W  = 64;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXSS = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CORR  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // Alignment of each partial product inside the 64-bit accumulator
    localparam int unsigned PP_SHIFT_LL = 0;
    localparam int unsigned PP_SHIFT_LH = 16;
    localparam int unsigned PP_SHIFT_HL = 16;
    localparam int unsigned PP_SHIFT_HH = 32;

    // Shift for the partial product issued with counter value k
    function automatic logic [5:0] pp_shift(input logic [1:0] k);
        case (k)
            2'd0:    return 6'(PP_SHIFT_LL);
            2'd1:    return 6'(PP_SHIFT_LH);
            2'd2:    return 6'(PP_SHIFT_HL);
            default: return 6'(PP_SHIFT_HH);
        endcase
    endfunction

endpackage

// File: rtl/challengeqsys_mul_pp16.sv
// Registered 16x16 unsigned multiplier cell with enable and synchronous clear.
// Ports: clk; clr_i sync clear; en_i load enable; a_i/b_i 16-bit operands;
//        p_o 32-bit registered product.
module challengeqsys_mul_pp16
    import challengeqsys_mul_pkg::*;
(
    input  logic              clk,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [HALF_W-1:0] a_i,
    input  logic [HALF_W-1:0] b_i,
    output logic [PROD_W-1:0] p_o
);

    logic [PROD_W-1:0] p_q;

    // Product register; holds its value while disabled
    always_ff @(posedge clk) begin
        if (clr_i) begin
            p_q <= '0;
        end else if (en_i) begin
            p_q <= PROD_W'(a_i) * PROD_W'(b_i);
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/challengeqsys_mul_sequencer.sv
// Nios-style MUL/MULX sequencer: builds the 64-bit product from four 16x16
// partial products on one shared registered cell, then applies the signed
// high-word correction for MULXSU/MULXSS.
// Ports: clk, reset (sync, active-high); req_valid/req_ready/req_a/req_b/req_op
//        request channel; cancel aborts an in-flight op; rsp_valid/rsp_ready/
//        rsp_data response channel; busy high whenever not idle.
module challengeqsys_mul_sequencer
    import challengeqsys_mul_pkg::*;
#(
    parameter int unsigned MUL_SHORTCUT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [1:0]  req_op,
    input  logic        cancel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy
);

    state_e             state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WORD_W-1:0]  a_q, a_d, b_q, b_d;
    op_e                op_q, op_d;
    logic               pp_vld_q, pp_vld_d;
    logic [1:0]         pp_k_q, pp_k_d;
    logic               req_ready_q, rsp_valid_q, busy_q;
    logic [WORD_W-1:0]  rsp_data_q, rsp_data_d;

    logic               cell_en;
    logic [HALF_W-1:0]  cell_a, cell_b;
    logic [PROD_W-1:0]  cell_p;
    logic [1:0]         last_k;
    logic [WORD_W-1:0]  sub_b, sub_a;

    challengeqsys_mul_pp16 u_pp16 (
        .clk   (clk),
        .clr_i (reset),
        .en_i  (cell_en),
        .a_i   (cell_a),
        .b_i   (cell_b),
        .p_o   (cell_p)
    );

    // Next-state, datapath and response selection
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        pp_vld_d = 1'b0;
        pp_k_d   = k_q;
        cell_en  = 1'b0;
        // k[1] picks the a half, k[0] the b half: ll, lh, hl, hh
        cell_a   = k_q[1] ? a_q[31:16] : a_q[15:0];
        cell_b   = k_q[0] ? b_q[31:16] : b_q[15:0];
        last_k   = (op_q == OP_MUL && MUL_SHORTCUT != 0) ? 2'd2 : 2'd3;
        sub_b    = (op_q inside {OP_MULXSU, OP_MULXSS} && a_q[31]) ? b_q : '0;
        sub_a    = (op_q == OP_MULXSS && b_q[31]) ? a_q : '0;

        // Cell output issued last cycle lands in the accumulator now
        if (pp_vld_q) begin
            acc_d = acc_q + (ACC_W'(cell_p) << pp_shift(pp_k_q));
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = op_e'(req_op);
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cell_en  = 1'b1;
                pp_vld_d = 1'b1;
                k_d      = k_q + 2'd1;
                if (k_q == last_k) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end
                if (cancel) begin
                    pp_vld_d = 1'b0;
                    k_d      = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                state_d = (op_q == OP_MUL) ? ST_RESP : ST_CORR;
                if (cancel) state_d = ST_IDLE;
            end
            ST_CORR: begin
                // Unsigned product to signed high word, modulo 2^32
                acc_d[63:32] = acc_q[63:32] - sub_b - sub_a;
                state_d      = cancel ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        rsp_data_d = '0;
        if (state_d == ST_RESP) begin
            rsp_data_d = (op_q == OP_MUL) ? acc_d[31:0] : acc_d[63:32];
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_MUL;
            pp_vld_q    <= 1'b0;
            pp_k_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            pp_vld_q    <= pp_vld_d;
            pp_k_q      <= pp_k_d;
            req_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            rsp_data_q  <= rsp_data_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_challengeqsys_mul_sequencer.sv
// Self-checking bench for challengeqsys_mul_sequencer: a transaction-level
// model (age since acceptance vs. fixed latency) predicts every output each
// cycle; directed cases pin literal results and timing.
module tb_challengeqsys_mul_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a, req_b;
    logic [1:0]  req_op;
    logic        cancel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Model state
    logic        m_act   = 1'b0;
    int          m_age   = 0;
    int          m_lat   = 0;
    logic [31:0] m_res   = '0;
    logic        m_ready = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    logic        m_busy  = 1'b0;

    challengeqsys_mul_sequencer #(.MUL_SHORTCUT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .cancel    (cancel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s bound expired at %0t", name, $time);
    endfunction

    // Architectural result computed with 64-bit sign/zero extension
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = op[1]        ? {{32{a[31]}}, a} : {32'd0, a};
        xb = (op == 2'b11) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Transaction model: result due a fixed number of cycles after acceptance
    always @(posedge clk) begin
        if (reset) begin
            m_act   = 1'b0;
            m_ready = 1'b0;
        end else begin
            if (!m_act) begin
                if (req_valid && m_ready) begin
                    m_act = 1'b1;
                    m_age = 1;
                    m_res = ref_mul(req_op, req_a, req_b);
                    m_lat = (req_op == 2'b00) ? 5 : 7;
                end
            end else if (m_age < m_lat) begin
                if (cancel) m_act = 1'b0;
                else        m_age++;
            end else begin
                if (rsp_ready) m_act = 1'b0;
                else           m_age++;
            end
            m_ready = !m_act;
        end
        m_busy  = m_act;
        m_valid = m_act && (m_age >= m_lat);
        m_data  = m_valid ? m_res : 32'd0;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("req_ready", 32'(req_ready), 32'(m_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_data",  rsp_data,       m_data);
        chk("busy",      32'(busy),      32'(m_busy));
    end

    // Wait (bounded) until the DUT is ready; returns with the cycle T0 current
    task automatic wait_accept(output logic ok);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (req_ready === 1'b1);
        if (!ok) fail_now("accept_wait");
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic lit_en, input logic [31:0] lit, input int bp);
        int          n;
        logic        ok;
        logic [31:0] d0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        rsp_ready = 1'b0; cancel = 1'b0;
        wait_accept(ok);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 2'($urandom_range(0, 3));
        n = 1;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid !== 1'b1) begin
            fail_now("rsp_wait");
            return;
        end
        chk("rsp_latency", 32'(n), (op == 2'b00) ? 32'd5 : 32'd7);
        if (lit_en) chk("rsp_literal", rsp_data, lit);
        d0 = rsp_data;
        repeat (bp) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data",  rsp_data, d0);
            chk("bp_busy",  32'(busy), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic ok;
        int   last;
        int   nresp;
        reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        cancel = 1'b0; rsp_ready = 1'b0;

        // Pin the reference model with hand-computed values
        chk("model_mul",  ref_mul(2'b00, 32'h0001_0003, 32'h0002_0005), 32'h000B_000F);
        chk("model_xuu",  ref_mul(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        chk("model_xsu",  ref_mul(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("model_xss",  ref_mul(2'b11, 32'h8000_0000, 32'h0000_0002), 32'hFFFF_FFFF);

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data",  rsp_data, 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Directed operations
        run_txn(2'b00, 32'h0001_0003, 32'h0002_0005, 1'b1, 32'h000B_000F, 0);
        run_txn(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 0);
        run_txn(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 0);
        run_txn(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 0);
        run_txn(2'b11, 32'h8000_0000, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 3);

        // Cancel during ISSUE at T0+3
        req_valid = 1'b1; req_op = 2'b00; req_a = $urandom; req_b = $urandom;
        wait_accept(ok);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        chk("cancel_ready", 32'(req_ready), 32'd1);
        chk("cancel_busy",  32'(busy), 32'd0);
        repeat (8) begin
            @(negedge clk);
            chk("cancel_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_txn(2'b00, 32'd3, 32'd5, 1'b1, 32'h0000_000F, 0);

        // Reset at T0+2
        req_valid = 1'b1; req_op = 2'b11; req_a = $urandom; req_b = $urandom;
        wait_accept(ok);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_data",  rsp_data, 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        @(negedge clk);
        run_txn(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0001, 0);

        // Back-to-back MULs with req_valid and rsp_ready held high
        req_valid = 1'b1; rsp_ready = 1'b1; req_op = 2'b00;
        last = -1; nresp = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            req_a = $urandom; req_b = $urandom;
            if (rsp_valid === 1'b1) begin
                if (last >= 0) chk("b2b_gap", 32'(c - last), 32'd6);
                last = c;
                nresp++;
            end
        end
        chk("b2b_count", 32'(nresp >= 6), 32'd1);
        req_valid = 1'b0; rsp_ready = 1'b0;
        repeat (10) @(negedge clk);

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 3) != 0);
            req_op    = 2'($urandom_range(0, 3));
            req_a     = pick();
            req_b     = pick();
            rsp_ready = ($urandom_range(0, 3) != 0);
            cancel    = ($urandom_range(0, 9) == 0);
            reset     = !reset && ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        req_valid = 1'b0; cancel = 1'b0; reset = 1'b0; rsp_ready = 1'b1;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
